capture_buffer: RTL and testbench

Trigger-qualified sample recorder. It sits directly downstream of pattern_detector: sample_in is driven by out_data and trigger by detected. Both come from the same register stage, so they are cycle-aligned.
Once armed, it continuously stores samples in a circular RAM. On an accepted trigger it keeps PRE_TRIG samples before the trigger, the trigger sample, and the post-trigger samples, then freezes. Firmware or a readout stage then reads the DEPTH-sample window back one byte per request.

---
 rtl/tla_pkg.sv | 17 +
 rtl/capture_ram.sv | 36 +++
 rtl/capture_buffer.sv | 125 ++++++++++++
 tb/tb_capture_buffer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tla_pkg.sv
// Shared state codes, default sample width and pointer width helper for the capture path.
package tla_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_DATA_W = 8;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/capture_ram.sv
// Sample storage: one synchronous write port, one synchronous read port (1-cycle read latency).
// Read data register resets to 0 and holds its value when no read is requested.
module capture_ram
    import tla_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 16,
    parameter int AW     = ptr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/capture_buffer.sv
// Trigger-qualified circular sample recorder with PRE_TRIG history, frozen window readout.
// Readout: rd_valid/rd_data one cycle after rd_req; sample_valid gaps simply stall capture.
module capture_buffer
    import tla_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = 16,
    parameter int PRE_TRIG = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic              trigger,
    input  logic              rd_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [1:0]        state,
    output logic              done
);

    localparam int AW = ptr_w(DEPTH);
    localparam int FW = AW + 1;
    localparam logic [FW-1:0] FILL_MAX  = FW'(DEPTH);
    localparam logic [FW-1:0] FILL_PRE  = FW'(PRE_TRIG);
    localparam logic [AW-1:0] PRE_OFS   = AW'(PRE_TRIG);
    localparam logic [AW-1:0] POST_INIT = AW'(DEPTH - PRE_TRIG - 1);

    state_t          st;
    logic [AW-1:0]   wr_ptr;
    logic [FW-1:0]   fill_cnt;
    logic [AW-1:0]   post_cnt;
    logic [AW-1:0]   start_ptr;
    logic [AW-1:0]   rd_idx;

    logic            wr_en;
    logic            rd_en;
    logic            trig_ok;
    logic [AW-1:0]   rd_addr;

    // arm pre-empts both ports in the cycle it is asserted
    assign wr_en   = sample_valid && !arm && (st == ST_ARMED || st == ST_POST);
    assign rd_en   = rd_req && !arm && (st == ST_DONE);
    assign trig_ok = trigger && (fill_cnt >= FILL_PRE);
    assign rd_addr = start_ptr + rd_idx;
    assign state   = st;

    capture_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (sample_in),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= ST_IDLE;
            wr_ptr    <= '0;
            fill_cnt  <= '0;
            post_cnt  <= '0;
            start_ptr <= '0;
            rd_idx    <= '0;
            done      <= 1'b0;
            rd_valid  <= 1'b0;
        end else if (arm) begin
            st       <= ST_ARMED;
            wr_ptr   <= '0;
            fill_cnt <= '0;
            rd_idx   <= '0;
            done     <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            case (st)
                ST_ARMED: begin
                    if (sample_valid) begin
                        wr_ptr <= wr_ptr + AW'(1);
                        if (fill_cnt != FILL_MAX) begin
                            fill_cnt <= fill_cnt + FW'(1);
                        end
                        if (trig_ok) begin
                            // wr_ptr still addresses the trigger sample here
                            start_ptr <= wr_ptr - PRE_OFS;
                            post_cnt  <= POST_INIT;
                            if (POST_INIT == '0) begin
                                st   <= ST_DONE;
                                done <= 1'b1;
                            end else begin
                                st <= ST_POST;
                            end
                        end
                    end
                end
                ST_POST: begin
                    if (sample_valid) begin
                        wr_ptr   <= wr_ptr + AW'(1);
                        post_cnt <= post_cnt - AW'(1);
                        if (post_cnt == AW'(1)) begin
                            st   <= ST_DONE;
                            done <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (rd_req) begin
                        rd_idx <= rd_idx + AW'(1);
                    end
                end
                default: begin
                    st <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_capture_buffer.sv
// Directed bench for capture_buffer (DEPTH=16, PRE_TRIG=4); one task per scenario.
module tb_capture_buffer;

    localparam int DATA_W   = 8;
    localparam int DEPTH    = 16;
    localparam int PRE_TRIG = 4;

    logic              clk;
    logic              rst_n;
    logic              arm;
    logic [DATA_W-1:0] sample_in;
    logic              sample_valid;
    logic              trigger;
    logic              rd_req;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [1:0]        state;
    logic              done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] got_d [DEPTH];
    logic              got_v [DEPTH];

    capture_buffer #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .PRE_TRIG (PRE_TRIG)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .arm          (arm),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .trigger      (trigger),
        .rd_req       (rd_req),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .state        (state),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        cyc();
        arm = 1'b0;
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input logic t);
        sample_valid = 1'b1;
        sample_in    = d;
        trigger      = t;
        cyc();
        sample_valid = 1'b0;
        trigger      = 1'b0;
    endtask

    task automatic read_window();
        for (int i = 0; i < DEPTH; i++) begin
            rd_req = 1'b1;
            cyc();
            got_v[i] = rd_valid;
            got_d[i] = rd_data;
        end
        rd_req = 1'b0;
    endtask

    task automatic test_reset();
        cyc();
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (state !== 2'd0 || done !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs got state=%0d done=%b rd_valid=%b rd_data=%h want 0/0/0/00",
                     state, done, rd_valid, rd_data);
        end
        cyc();
        rst_n = 1'b1;
        cyc();
        rd_req = 1'b1;
        cyc();
        rd_req = 1'b0;
        n_checks++;
        if (rd_valid !== 1'b0 || state !== 2'd0) begin
            n_fail++;
            $display("FAIL idle_rd_req got rd_valid=%b state=%0d want 0/0", rd_valid, state);
        end
    endtask

    task automatic test_basic();
        do_arm();
        n_checks++;
        if (state !== 2'd1) begin
            n_fail++;
            $display("FAIL basic_armed got state=%0d want 1", state);
        end
        for (int i = 0; i <= 9; i++) send(DATA_W'(i), i == 9);
        n_checks++;
        if (state !== 2'd2) begin
            n_fail++;
            $display("FAIL basic_post got state=%0d want 2", state);
        end
        for (int i = 10; i <= 19; i++) send(DATA_W'(i), 1'b0);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_not_done got done=%b want 0", done);
        end
        send(8'h14, 1'b0);
        n_checks++;
        if (done !== 1'b1 || state !== 2'd3) begin
            n_fail++;
            $display("FAIL basic_done got done=%b state=%0d want 1/3", done, state);
        end
        read_window();
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (got_v[i] !== 1'b1 || got_d[i] !== DATA_W'(5 + i)) begin
                n_fail++;
                $display("FAIL basic_read[%0d] got v=%b d=%h want 1/%h", i, got_v[i], got_d[i], DATA_W'(5 + i));
            end
        end
        cyc();
        n_checks++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h14) begin
            n_fail++;
            $display("FAIL basic_idle_hold got v=%b d=%h want 0/14", rd_valid, rd_data);
        end
        rd_req = 1'b1;
        cyc();
        rd_req = 1'b0;
        n_checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h05) begin
            n_fail++;
            $display("FAIL basic_wrap_read got v=%b d=%h want 1/05", rd_valid, rd_data);
        end
    endtask

    task automatic test_early_trigger();
        do_arm();
        send(8'h00, 1'b0);
        send(8'h01, 1'b1);
        n_checks++;
        if (state !== 2'd1) begin
            n_fail++;
            $display("FAIL early_ignored got state=%0d want 1", state);
        end
        for (int i = 2; i <= 5; i++) send(DATA_W'(i), 1'b0);
        trigger = 1'b1;
        cyc();
        trigger = 1'b0;
        n_checks++;
        if (state !== 2'd1) begin
            n_fail++;
            $display("FAIL trig_no_valid got state=%0d want 1", state);
        end
        send(8'h06, 1'b1);
        n_checks++;
        if (state !== 2'd2) begin
            n_fail++;
            $display("FAIL early_accept got state=%0d want 2", state);
        end
        for (int i = 7; i <= 17; i++) send(DATA_W'(i), 1'b0);
        read_window();
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (got_v[i] !== 1'b1 || got_d[i] !== DATA_W'(2 + i)) begin
                n_fail++;
                $display("FAIL early_read[%0d] got v=%b d=%h want 1/%h", i, got_v[i], got_d[i], DATA_W'(2 + i));
            end
        end
    endtask

    task automatic test_wrap();
        do_arm();
        for (int i = 0; i <= 39; i++) send(DATA_W'(i), i == 39);
        for (int i = 40; i <= 50; i++) send(DATA_W'(i), 1'b0);
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_done got done=%b want 1", done);
        end
        read_window();
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (got_d[i] !== DATA_W'(35 + i)) begin
                n_fail++;
                $display("FAIL wrap_read[%0d] got %h want %h", i, got_d[i], DATA_W'(35 + i));
            end
        end
    endtask

    task automatic test_stall();
        do_arm();
        for (int i = 0; i <= 4; i++) send(DATA_W'(i), i == 4);
        for (int i = 5; i <= 15; i++) begin
            sample_valid = 1'b0;
            sample_in    = 8'hEE;
            trigger      = 1'b1;
            cyc();
            if (i == 15) begin
                n_checks++;
                if (state !== 2'd2 || done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_hold got state=%0d done=%b want 2/0", state, done);
                end
            end
            send(DATA_W'(i), 1'b1);
        end
        n_checks++;
        if (state !== 2'd3) begin
            n_fail++;
            $display("FAIL stall_done got state=%0d want 3", state);
        end
        read_window();
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (got_d[i] !== DATA_W'(i)) begin
                n_fail++;
                $display("FAIL stall_read[%0d] got %h want %h", i, got_d[i], DATA_W'(i));
            end
        end
    endtask

    task automatic test_abort_reset();
        do_arm();
        for (int i = 0; i <= 6; i++) send(DATA_W'(i), i == 4);
        n_checks++;
        if (state !== 2'd2) begin
            n_fail++;
            $display("FAIL abort_pre got state=%0d want 2", state);
        end
        do_arm();
        n_checks++;
        if (state !== 2'd1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_rearm got state=%0d done=%b want 1/0", state, done);
        end
        for (int i = 8'h80; i <= 8'h8E; i++) send(DATA_W'(i), i == 8'h84);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_not_done got done=%b want 0", done);
        end
        send(8'h8F, 1'b0);
        read_window();
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (got_d[i] !== DATA_W'(8'h80 + i)) begin
                n_fail++;
                $display("FAIL abort_read[%0d] got %h want %h", i, got_d[i], DATA_W'(8'h80 + i));
            end
        end
        arm    = 1'b1;
        rd_req = 1'b1;
        cyc();
        arm    = 1'b0;
        rd_req = 1'b0;
        n_checks++;
        if (rd_valid !== 1'b0 || state !== 2'd1) begin
            n_fail++;
            $display("FAIL arm_vs_rd got v=%b state=%0d want 0/1", rd_valid, state);
        end
        for (int i = 8'h40; i <= 8'h4F; i++) send(DATA_W'(i), i == 8'h44);
        rd_req = 1'b1;
        cyc();
        rd_req = 1'b0;
        n_checks++;
        if (done !== 1'b1 || rd_data !== 8'h40) begin
            n_fail++;
            $display("FAIL recap_read got done=%b d=%h want 1/40", done, rd_data);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (done !== 1'b0 || state !== 2'd0 || rd_data !== 8'h00 || rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL done_reset got done=%b state=%0d d=%h v=%b want 0/0/00/0",
                     done, state, rd_data, rd_valid);
        end
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n        = 1'b1;
        arm          = 1'b0;
        sample_in    = '0;
        sample_valid = 1'b0;
        trigger      = 1'b0;
        rd_req       = 1'b0;
        test_reset();
        test_basic();
        test_early_trigger();
        test_wrap();
        test_stall();
        test_abort_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
